// File: rtl/inst_imm_gen_if.sv
// Instruction/immediate bus between a fetch-side driver and the imm generator.
// The master drives the instruction. The slave returns both the same-cycle
// decode and the registered, valid-qualified copy.
interface inst_imm_gen_if #(
  parameter int XLEN = 64
);
  logic [31:0]     inst;
  logic            in_valid;
  logic [2:0]      inst_type;
  logic [XLEN-1:0] imm;
  logic [2:0]      inst_type_q;
  logic [XLEN-1:0] imm_q;
  logic            out_valid;

  modport master (
    output inst, in_valid,
    input  inst_type, imm, inst_type_q, imm_q, out_valid
  );

  modport slave (
    input  inst, in_valid,
    output inst_type, imm, inst_type_q, imm_q, out_valid
  );
endinterface

// File: rtl/inst_imm_gen.sv
// RV64 instruction format classifier and immediate generator.
// The combinational outputs are for same-cycle decode. The registered copy,
// qualified by out_valid, is for the next pipeline stage.
module inst_imm_gen #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  inst_imm_gen_if.slave bus
);

  typedef enum logic [2:0] {
    T_NONE = 3'd0,
    T_R    = 3'd1,
    T_I    = 3'd2,
    T_S    = 3'd3,
    T_B    = 3'd4,
    T_U    = 3'd5,
    T_J    = 3'd6
  } itype_e;

  typedef struct packed {
    logic [2:0]      typ;
    logic [XLEN-1:0] imm;
  } rsp_t;

  localparam int STAGES = 1;

  logic [31:0]     inst;
  itype_e          typ;
  logic [XLEN-1:0] imm;
  rsp_t            rsp_q;
  logic [STAGES:0] vld_pipe;

  assign inst = bus.inst;

  // Opcode to format. SYSTEM is treated as I so that its funct12/CSR field comes out as imm.
  always_comb begin
    typ = T_NONE;
    case (inst[6:0])
      7'b0110011, 7'b0111011:                       typ = T_R;
      7'b0010011, 7'b0011011, 7'b0000011,
      7'b1100111, 7'b1110011:                       typ = T_I;
      7'b0100011:                                   typ = T_S;
      7'b1100011:                                   typ = T_B;
      7'b0010111, 7'b0110111:                       typ = T_U;
      7'b1101111:                                   typ = T_J;
      default:                                      typ = T_NONE;
    endcase
  end

  // Immediate assembly per format. Shift-immediate funct7 bits are kept in place.
  always_comb begin
    imm = '0;
    case (typ)
      T_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      T_S: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      T_B: imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U: imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      T_J: imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign bus.inst_type = typ;
  assign bus.imm       = imm;

  // Valid shift register. Stage 0 is the incoming qualifier.
  assign vld_pipe[0] = bus.in_valid;

  // Valid pipeline. Reset wins and clears out_valid on the same edge.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Capture register. It loads only on valid input and otherwise holds its value.
  always_ff @(posedge clk) begin
    if (rst)              rsp_q <= '0;
    else if (vld_pipe[0]) rsp_q <= '{typ: typ, imm: imm};
  end

  assign bus.inst_type_q = rsp_q.typ;
  assign bus.imm_q       = rsp_q.imm;
  assign bus.out_valid   = vld_pipe[STAGES];

endmodule

// File: tb/tb_inst_imm_gen.sv
// Randomized scoreboard bench for inst_imm_gen. The driver pushes the expected
// registered state for each edge. A monitor compares that state on the following negedge.
module tb_inst_imm_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  inst_imm_gen_if #(.XLEN(64)) bus ();

  inst_imm_gen #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        ov;
    logic [2:0]  t;
    logic [63:0] i;
  } exp_t;

  exp_t exp_q[$];
  logic [2:0]  h_t = 3'd0;
  logic [63:0] h_i = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference classification, read straight from the opcode table.
  function automatic logic [2:0] m_type(input logic [31:0] x);
    case (x[6:0])
      7'h33, 7'h3B:                      return 3'd1;
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h73: return 3'd2;
      7'h23:                             return 3'd3;
      7'h63:                             return 3'd4;
      7'h17, 7'h37:                      return 3'd5;
      7'h6F:                             return 3'd6;
      default:                           return 3'd0;
    endcase
  endfunction

  // Reference immediate: each field is weighted by its place value, and the sign bit carries a negative weight.
  function automatic logic [63:0] m_imm(input logic [31:0] x);
    longint v;
    longint s;
    s = x[31] ? 1 : 0;
    case (m_type(x))
      3'd2: v = longint'(x[30:20]) - s * 2048;
      3'd3: v = longint'(x[30:25]) * 32 + longint'(x[11:7]) - s * 2048;
      3'd4: v = longint'(x[7]) * 2048 + longint'(x[30:25]) * 32
               + longint'(x[11:8]) * 2 - s * 4096;
      3'd5: v = longint'(x[30:12]) * 4096 - s * 64'sh8000_0000;
      3'd6: v = longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048
               + longint'(x[30:21]) * 2 - s * 1048576;
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  // Drive one cycle. When use_e is set, the comb outputs are checked against the given constants instead of the model.
  task automatic step(input logic [31:0] i, input logic v, input logic r,
                      input logic use_e, input logic [2:0] et, input logic [63:0] ei,
                      input string tag);
    logic [2:0]  t;
    logic [63:0] im;
    exp_t e;
    @(posedge clk);
    #1;
    bus.inst = i;
    bus.in_valid = v;
    rst = r;
    #1;
    t  = use_e ? et : m_type(i);
    im = use_e ? ei : m_imm(i);
    chk({tag, ".type"}, 64'(bus.inst_type), 64'(t));
    chk({tag, ".imm"}, bus.imm, im);
    if (r) begin
      h_t = 3'd0; h_i = 64'd0; e.ov = 1'b0;
    end else if (v) begin
      h_t = t; h_i = im; e.ov = 1'b1;
    end else begin
      e.ov = 1'b0;
    end
    e.cyc = cyc + 1;
    e.t = h_t;
    e.i = h_i;
    exp_q.push_back(e);
  endtask

  // Monitor: on each negedge, compare the registered outputs with what was expected for the edge just taken.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("q.out_valid", 64'(bus.out_valid), 64'(e.ov));
        chk("q.type", 64'(bus.inst_type_q), 64'(e.t));
        chk("q.imm", bus.imm_q, e.i);
      end
    end
  end

  // Watchdog in case the clock or the flow stalls.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d items pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ri;
    logic [6:0]  opc [11];
    opc = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h17, 7'h37};
    bus.inst = 32'h0;
    bus.in_valid = 1'b0;

    step(32'h0000_0013, 1'b0, 1'b1, 1'b0, 3'd0, 64'd0, "rst0");
    step(32'h0000_0013, 1'b0, 1'b1, 1'b0, 3'd0, 64'd0, "rst1");
    step(32'hFFF0_0093, 1'b1, 1'b0, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, "addi");
    step(32'h0000_0073, 1'b1, 1'b0, 1'b1, 3'd2, 64'h0, "ecall");
    step(32'h0010_0073, 1'b1, 1'b0, 1'b1, 3'd2, 64'h1, "ebreak");
    step(32'h3020_0073, 1'b1, 1'b0, 1'b1, 3'd2, 64'h302, "mret");
    step(32'hFE20_BC23, 1'b1, 1'b0, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, "sd");
    step(32'hFE00_0EE3, 1'b1, 1'b0, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, "beq");
    step(32'h8000_02B7, 1'b1, 1'b0, 1'b1, 3'd5, 64'hFFFF_FFFF_8000_0000, "lui");
    step(32'h0010_00EF, 1'b1, 1'b0, 1'b1, 3'd6, 64'h800, "jal");
    step(32'h0020_8033, 1'b1, 1'b0, 1'b1, 3'd1, 64'h0, "add");
    step(32'h4030_D093, 1'b1, 1'b0, 1'b1, 3'd2, 64'h403, "srai");
    step(32'h0000_007F, 1'b1, 1'b0, 1'b1, 3'd0, 64'h0, "illegal");
    step(32'hFFF0_0093, 1'b1, 1'b0, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, "addi2");
    step(32'h8000_02B7, 1'b0, 1'b0, 1'b1, 3'd5, 64'hFFFF_FFFF_8000_0000, "hold0");
    step(32'h0010_00EF, 1'b0, 1'b0, 1'b1, 3'd6, 64'h800, "hold1");
    step(32'hFE20_BC23, 1'b1, 1'b1, 1'b1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, "rst_pri");
    step(32'hFE00_0EE3, 1'b1, 1'b0, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, "resume");

    for (int k = 0; k < 600; k++) begin
      ri = $urandom;
      if ($urandom_range(0, 7) != 0) ri[6:0] = opc[$urandom_range(0, 10)];
      else if ($urandom_range(0, 1) == 0) ri[6:0] = 7'h6F;
      step(ri, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
           1'b0, 3'd0, 64'd0, "rand");
    end

    step(32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, "tail");
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard.drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_imm_gen.md
Name: inst_imm_gen

Overview:
- Classifies a 32-bit RV64 instruction into a format type (R/I/S/B/U/J/none) and produces the sign-extended 64-bit immediate for that format.
- Sits at the front of the decode stage and feeds the decoder's imm and control logic.
- Provides combinational outputs for same-cycle use.
- Also provides a registered, valid-qualified copy for pipelined consumers.

Parameters:
- XLEN, 64, immediate output width; sign extension fills bits XLEN-1 down to the format's top bit.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- inst  input  32  instruction word
- in_valid  input  1  inst is valid this cycle; enables register capture
- inst_type  output  3  combinational format code of inst
- imm  output  XLEN  combinational sign-extended immediate of inst
- inst_type_q  output  3  registered inst_type
- imm_q  output  XLEN  registered imm
- out_valid  output  1  registered in_valid; qualifies inst_type_q and imm_q

Behaviour:
- Type codes: NONE=0, R=1, I=2, S=3, B=4, U=5, J=6. Code 7 is never produced.
- Opcode map (inst[6:0]):
  - 0110011 and 0111011 -> R
  - 0010011, 0011011, 0000011, 1100111 and 1110011 -> I (SYSTEM is I-type)
  - 0100011 -> S
  - 1100011 -> B
  - 0010111 and 0110111 -> U
  - 1101111 -> J
  - any other opcode -> NONE
- Immediate by type; sext extends from the MSB shown:
  - R -> 0
  - I -> sext(inst[31:20]). For shift-immediates, funct7 bits are left in place (srai gives 0x400|shamt).
  - S -> sext({inst[31:25], inst[11:7]})
  - B -> sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U -> sext({inst[31:12], 12'b0}); bits 63:32 copy inst[31]
  - J -> sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - NONE -> 0
- SYSTEM immediate consequences the decoder relies on: ecall gives imm=0, ebreak gives imm=1, mret gives imm=0x302, CSR ops give imm=CSR address.
- Combinational path: no latency, purely a function of inst. It does not depend on rst or in_valid.
- Registered path, on rising clk:
  - rst=1: inst_type_q=0 (NONE), imm_q=0, out_valid=0. Reset has priority over in_valid.
  - else in_valid=1: inst_type_q<=inst_type, imm_q<=imm, out_valid<=1.
  - else: inst_type_q and imm_q hold their values; out_valid<=0.
- Latency of the registered path is 1 cycle. No backpressure and no handshake beyond in_valid/out_valid.
- Outputs carry no X for any 32-bit inst value, including illegal encodings.
- Reset asserted mid-stream clears the registered outputs on that edge. Capture resumes the first edge after rst deasserts.

Test Plan:
- Reset then I-format: rst=1 for 2 cycles -> inst_type_q=0, imm_q=0, out_valid=0. Then addi x1,x0,-1 (0xFFF00093), in_valid=1 -> inst_type=2, imm=0xFFFFFFFFFFFFFFFF; registered copies match one cycle later with out_valid=1.
- SYSTEM immediates: 0x00000073 -> I, imm 0. 0x00100073 -> I, imm 1. 0x30200073 -> I, imm 0x302.
- S-format: sd x2,-8(x1) = 0xFE20BC23 -> S, imm 0xFFFFFFFFFFFFFFF8.
- B-format: beq x0,x0,-4 = 0xFE000EE3 -> B, imm 0xFFFFFFFFFFFFFFFC.
- U and J formats:
  - lui x5,0x80000 = 0x800002B7 -> U, imm 0xFFFFFFFF80000000.
  - jal x1,+2048 = 0x001000EF -> J, imm 0x800.
  - add = 0x00208033 -> R, imm 0.
- Invalid input and hold/priority:
  - 0x0000007F -> NONE, imm 0.
  - in_valid=0 -> q values held and out_valid=0.
  - rst=1 together with in_valid=1 -> registered outputs cleared.
